// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned BUF_W = 24;

  localparam logic [1:0] CU_BYTE = 2'd0;
  localparam logic [1:0] CU_HALF = 2'd1;
  localparam logic [1:0] CU_WORD = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_MM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // A count code of 2 has no three-byte meaning and is promoted to a word.
  function automatic logic [1:0] cu_to_nm1(input logic [1:0] cu);
    return (cu == 2'd2) ? CU_WORD : cu;
  endfunction

  function automatic logic [BUF_W-1:0] buf_insert(input logic [BUF_W-1:0] cur,
                                                  input logic [1:0]       idx,
                                                  input logic [7:0]       dat);
    logic [BUF_W-1:0] res;
    res = cur;
    case (idx)
      2'd0:    res[7:0]   = dat;
      2'd1:    res[15:8]  = dat;
      2'd2:    res[23:16] = dat;
      default: res        = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the fetch and data ports onto one 8-bit RAM port, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter bit          IF_ALLOW_ABORT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_e,
  input  logic [ADDR_W-1:0] if_a,
  output logic [31:0]       if_n_o,
  output logic              if_ok,
  input  logic              mm_e,
  input  logic [ADDR_W-1:0] mm_a,
  input  logic [31:0]       mm_n_i,
  input  logic              mm_wr,
  input  logic [1:0]        mm_cu,
  output logic [31:0]       mm_n_o,
  output logic              mm_ok,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         nm1_q, nm1_d;
  logic               port_q, port_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]  mem_a_q, mem_a_d;
  logic [7:0]         mem_dout_q, mem_dout_d;
  logic               mem_wr_q, mem_wr_d;
  logic               if_ok_q, if_ok_d;
  logic               mm_ok_q, mm_ok_d;
  logic [31:0]        if_n_q, if_n_d;
  logic [31:0]        mm_n_q, mm_n_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    nm1_d      = nm1_q;
    port_d     = port_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    if_ok_d    = 1'b0;
    mm_ok_d    = 1'b0;
    if_n_d     = 32'h0;
    mm_n_d     = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (mm_e) begin
          base_d  = mm_a;
          nm1_d   = cu_to_nm1(mm_cu);
          port_d  = PORT_MM;
          cnt_d   = 2'd0;
          buf_d   = '0;
          mem_a_d = mm_a;
          if (mm_wr) begin
            state_d    = ST_WR;
            mem_wr_d   = 1'b1;
            mem_dout_d = mm_n_i[7:0];
            mm_ok_d    = (nm1_d == 2'd0);
          end else begin
            state_d = ST_RD;
          end
        end else if (if_e) begin
          base_d  = if_a;
          nm1_d   = CU_WORD;
          port_d  = PORT_IF;
          cnt_d   = 2'd0;
          buf_d   = '0;
          mem_a_d = if_a;
          state_d = ST_RD;
        end
      end

      ST_RD: begin
        if (if_ok_q || mm_ok_q) begin
          state_d = ST_IDLE;
        end else if (IF_ALLOW_ABORT && (port_q == PORT_IF) && !if_e) begin
          state_d = ST_IDLE;
        end else begin
          // mem_din carries the byte addressed one cycle earlier.
          if (cnt_q != 2'd0) begin
            buf_d = buf_insert(buf_q, cnt_q - 2'd1, mem_din);
          end
          if (cnt_q == nm1_q) begin
            if (port_q == PORT_IF) begin
              if_ok_d = 1'b1;
              if_n_d  = {8'h00, buf_d};
            end else begin
              mm_ok_d = 1'b1;
              mm_n_d  = {8'h00, buf_d};
            end
          end else begin
            cnt_d   = cnt_q + 2'd1;
            mem_a_d = base_q + ADDR_W'(cnt_d);
          end
        end
      end

      ST_WR: begin
        if (mm_ok_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_a_d    = base_q + ADDR_W'(cnt_d);
          mem_dout_d = mm_n_i[{cnt_d, 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          mm_ok_d    = (cnt_d == nm1_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      cnt_q      <= 2'd0;
      nm1_q      <= 2'd0;
      port_q     <= PORT_IF;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h00;
      mem_wr_q   <= 1'b0;
      if_ok_q    <= 1'b0;
      mm_ok_q    <= 1'b0;
      if_n_q     <= 32'h0;
      mm_n_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      nm1_q      <= nm1_d;
      port_q     <= port_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_ok_q    <= if_ok_d;
      mm_ok_q    <= mm_ok_d;
      if_n_q     <= if_n_d;
      mm_n_q     <= mm_n_d;
    end
  end

  assign if_n_o   = if_n_q;
  assign if_ok    = if_ok_q;
  assign mm_n_o   = mm_n_q;
  assign mm_ok    = mm_ok_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scenario bench for mem_ctrl with a byte RAM model and a load-result scoreboard.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_e;
  logic [31:0] if_a;
  logic [31:0] if_n_o;
  logic        if_ok;
  logic        mm_e;
  logic [31:0] mm_a;
  logic [31:0] mm_n_i;
  logic        mm_wr;
  logic [1:0]  mm_cu;
  logic [31:0] mm_n_o;
  logic        mm_ok;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;

  int checks;
  int failures;

  typedef struct packed {
    logic        is_if;
    logic [31:0] n;
    logic [7:0]  last;
  } exp_t;

  exp_t sb[$];

  logic [7:0] init_mem [0:65535];
  logic [7:0] wr_mem   [0:65535];
  bit         wr_vld   [0:65535];

  mem_ctrl #(.ADDR_W(32), .IF_ALLOW_ABORT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_e(if_e), .if_a(if_a), .if_n_o(if_n_o), .if_ok(if_ok),
    .mm_e(mm_e), .mm_a(mm_a), .mm_n_i(mm_n_i), .mm_wr(mm_wr), .mm_cu(mm_cu),
    .mm_n_o(mm_n_o), .mm_ok(mm_ok),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    return wr_vld[a] ? wr_mem[a] : init_mem[a];
  endfunction

  // RAM: writes on strobe, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) begin
      wr_mem[mem_a[15:0]] <= mem_dout;
      wr_vld[mem_a[15:0]] <= 1'b1;
    end
    mem_din <= ram_rd(mem_a[15:0]);
  end

  function automatic exp_t model_load(input logic is_if, input logic [31:0] a, input int nbytes);
    exp_t e;
    e.is_if = is_if;
    e.n     = 32'h0;
    for (int k = 0; k < nbytes - 1; k++) e.n[8*k +: 8] = ram_rd(16'(a + 32'(k)));
    e.last = ram_rd(16'(a + 32'(nbytes - 1)));
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({if_ok, mm_ok, mem_wr} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {if_ok, mm_ok, mem_wr}); end
    checks++; if (if_n_o !== 32'h0) begin failures++; $display("FAIL rst_if_n got=%h exp=0", if_n_o); end
    checks++; if (mm_n_o !== 32'h0) begin failures++; $display("FAIL rst_mm_n got=%h exp=0", mm_n_o); end
    checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL rst_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin failures++; $display("FAIL rst_mem_dout got=%h exp=0", mem_dout); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_load();
    exp_t e;
    sb.push_back(model_load(1'b0, 32'h1000, 4));
    mm_a = 32'h1000; mm_wr = 1'b0; mm_cu = 2'd3; mm_e = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (mem_a !== 32'h1000 + 32'(k - 1)) begin failures++; $display("FAIL wl_addr k=%0d got=%h exp=%h", k, mem_a, 32'h1000 + 32'(k - 1)); end
      checks++; if ({mm_ok, mem_wr} !== 2'b00) begin failures++; $display("FAIL wl_early k=%0d got=%b exp=00", k, {mm_ok, mem_wr}); end
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (mm_ok !== 1'b1) begin failures++; $display("FAIL wl_ok got=%b exp=1", mm_ok); end
    checks++; if (mm_n_o !== e.n) begin failures++; $display("FAIL wl_data got=%h exp=%h", mm_n_o, e.n); end
    checks++; if (mem_din !== e.last) begin failures++; $display("FAIL wl_last got=%h exp=%h", mem_din, e.last); end
    mm_e = 1'b0;
    @(negedge clk);
    checks++; if ({mm_ok, mm_n_o} !== 33'h0) begin failures++; $display("FAIL wl_after got ok=%b n=%h exp 0", mm_ok, mm_n_o); end
  endtask

  task automatic test_byte_load();
    exp_t e;
    sb.push_back(model_load(1'b0, 32'h20, 1));
    mm_a = 32'h20; mm_wr = 1'b0; mm_cu = 2'd0; mm_e = 1'b1;
    @(negedge clk);
    checks++; if (mem_a !== 32'h20) begin failures++; $display("FAIL bl_addr got=%h exp=20", mem_a); end
    checks++; if ({mm_ok, mem_wr} !== 2'b00) begin failures++; $display("FAIL bl_early got=%b exp=00", {mm_ok, mem_wr}); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if ({mm_ok, mem_wr} !== 2'b10) begin failures++; $display("FAIL bl_ok got=%b exp=10", {mm_ok, mem_wr}); end
    checks++; if (mm_n_o !== e.n) begin failures++; $display("FAIL bl_data got=%h exp=%h", mm_n_o, e.n); end
    checks++; if (mem_din !== e.last) begin failures++; $display("FAIL bl_last got=%h exp=%h", mem_din, e.last); end
    mm_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_half_store();
    mm_a = 32'h40; mm_n_i = 32'h0000_BEEF; mm_wr = 1'b1; mm_cu = 2'd1; mm_e = 1'b1;
    @(negedge clk);
    checks++; if ({mem_wr, mm_ok} !== 2'b10) begin failures++; $display("FAIL hs_b0_strobe got=%b exp=10", {mem_wr, mm_ok}); end
    checks++; if ({mem_a, mem_dout} !== {32'h40, 8'hEF}) begin failures++; $display("FAIL hs_b0 got=%h/%h exp=40/ef", mem_a, mem_dout); end
    @(negedge clk);
    checks++; if ({mem_wr, mm_ok} !== 2'b11) begin failures++; $display("FAIL hs_b1_strobe got=%b exp=11", {mem_wr, mm_ok}); end
    checks++; if ({mem_a, mem_dout} !== {32'h41, 8'hBE}) begin failures++; $display("FAIL hs_b1 got=%h/%h exp=41/be", mem_a, mem_dout); end
    mm_e = 1'b0;
    @(negedge clk);
    checks++; if ({mem_wr, mm_ok} !== 2'b00) begin failures++; $display("FAIL hs_after got=%b exp=00", {mem_wr, mm_ok}); end
    checks++; if (ram_rd(16'h0041) !== 8'hBE) begin failures++; $display("FAIL hs_ram got=%h exp=be", ram_rd(16'h0041)); end
  endtask

  task automatic test_arbitration();
    exp_t e;
    int   k_ok;
    sb.push_back(model_load(1'b0, 32'h3000, 2));
    sb.push_back(model_load(1'b1, 32'h2000, 4));
    mm_a = 32'h3000; mm_wr = 1'b0; mm_cu = 2'd1; mm_e = 1'b1;
    if_a = 32'h2000; if_e = 1'b1;
    k_ok = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mm_ok || if_ok) begin k_ok = k; break; end
    end
    e = sb.pop_front();
    checks++; if (k_ok !== 3) begin failures++; $display("FAIL arb_mm_latency got=%0d exp=3", k_ok); end
    checks++; if ({mm_ok, if_ok} !== {~e.is_if, e.is_if}) begin failures++; $display("FAIL arb_winner got mm=%b if=%b exp mm=1", mm_ok, if_ok); end
    checks++; if ({mm_n_o, mem_din} !== {e.n, e.last}) begin failures++; $display("FAIL arb_mm_data got=%h/%h exp=%h/%h", mm_n_o, mem_din, e.n, e.last); end
    mm_e = 1'b0;
    k_ok = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (if_ok) begin k_ok = k; break; end
    end
    e = sb.pop_front();
    checks++; if (k_ok !== 6) begin failures++; $display("FAIL arb_if_latency got=%0d exp=6", k_ok); end
    checks++; if ({if_ok, mm_ok} !== {e.is_if, 1'b0}) begin failures++; $display("FAIL arb_if_ok got if=%b mm=%b exp if=1", if_ok, mm_ok); end
    checks++; if ({if_n_o, mem_din} !== {e.n, e.last}) begin failures++; $display("FAIL arb_if_data got=%h/%h exp=%h/%h", if_n_o, mem_din, e.n, e.last); end
    if_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    exp_t e;
    int   n_ok;
    int   k_ok;
    if_a = 32'h2000; if_e = 1'b1;
    @(negedge clk);
    checks++; if (mem_a !== 32'h2000) begin failures++; $display("FAIL ab_addr0 got=%h exp=2000", mem_a); end
    @(negedge clk);
    checks++; if (mem_a !== 32'h2001) begin failures++; $display("FAIL ab_addr1 got=%h exp=2001", mem_a); end
    if_e = 1'b0;
    n_ok = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_ok) n_ok++;
    end
    checks++; if (n_ok !== 0) begin failures++; $display("FAIL ab_no_ok got=%0d exp=0", n_ok); end
    sb.push_back(model_load(1'b0, 32'h20, 1));
    mm_a = 32'h20; mm_wr = 1'b0; mm_cu = 2'd0; mm_e = 1'b1;
    k_ok = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mm_ok) begin k_ok = k; break; end
    end
    e = sb.pop_front();
    checks++; if (k_ok !== 2) begin failures++; $display("FAIL ab_mm_latency got=%0d exp=2", k_ok); end
    checks++; if (mem_din !== e.last) begin failures++; $display("FAIL ab_mm_data got=%h exp=%h", mem_din, e.last); end
    mm_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    exp_t        e;
    logic [31:0] a;
    a = 32'hFFFF_FFFE;
    sb.push_back(model_load(1'b0, a, 4));
    mm_a = a; mm_wr = 1'b0; mm_cu = 2'd2; mm_e = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (mem_a !== a + 32'(k - 1)) begin failures++; $display("FAIL wr_addr k=%0d got=%h exp=%h", k, mem_a, a + 32'(k - 1)); end
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (mm_ok !== 1'b1) begin failures++; $display("FAIL wr_ok got=%b exp=1", mm_ok); end
    checks++; if ({mm_n_o, mem_din} !== {e.n, e.last}) begin failures++; $display("FAIL wr_data got=%h/%h exp=%h/%h", mm_n_o, mem_din, e.n, e.last); end
    mm_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    exp_t e;
    int   n_ok;
    int   k_ok;
    mm_a = 32'h50; mm_n_i = 32'hCAFE_F00D; mm_wr = 1'b1; mm_cu = 2'd3; mm_e = 1'b1;
    @(negedge clk);
    checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h50, 8'h0D}) begin failures++; $display("FAIL rs_b0 got=%b/%h/%h exp=1/50/0d", mem_wr, mem_a, mem_dout); end
    @(negedge clk);
    checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h51, 8'hF0}) begin failures++; $display("FAIL rs_b1 got=%b/%h/%h exp=1/51/f0", mem_wr, mem_a, mem_dout); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({mem_wr, mm_ok, if_ok} !== 3'b000) begin failures++; $display("FAIL rs_strobes got=%b exp=000", {mem_wr, mm_ok, if_ok}); end
    checks++; if ({mem_a, mem_dout, mm_n_o, if_n_o} !== 104'h0) begin failures++; $display("FAIL rs_outputs got=%h/%h/%h/%h exp 0", mem_a, mem_dout, mm_n_o, if_n_o); end
    mm_e = 1'b0;
    n_ok = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mm_ok) n_ok++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (mm_ok) n_ok++;
    checks++; if (n_ok !== 0) begin failures++; $display("FAIL rs_no_ok got=%0d exp=0", n_ok); end
    checks++; if (ram_rd(16'h0052) !== 8'h77) begin failures++; $display("FAIL rs_torn got=%h exp=77", ram_rd(16'h0052)); end
    e = '{is_if: 1'b0, n: 32'h0, last: 8'hF0};
    sb.push_back(e);
    mm_a = 32'h51; mm_wr = 1'b0; mm_cu = 2'd0; mm_e = 1'b1;
    k_ok = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mm_ok) begin k_ok = k; break; end
    end
    e = sb.pop_front();
    checks++; if (k_ok !== 2) begin failures++; $display("FAIL rs_new_latency got=%0d exp=2", k_ok); end
    checks++; if ({mm_n_o, mem_din} !== {e.n, e.last}) begin failures++; $display("FAIL rs_new_data got=%h/%h exp=%h/%h", mm_n_o, mem_din, e.n, e.last); end
    mm_e = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    if_e = 1'b0; if_a = 32'h0;
    mm_e = 1'b0; mm_a = 32'h0; mm_n_i = 32'h0; mm_wr = 1'b0; mm_cu = 2'd0;
    for (int i = 0; i < 65536; i++) begin
      init_mem[i] = 8'h00;
      wr_mem[i]   = 8'h00;
      wr_vld[i]   = 1'b0;
    end
    init_mem[16'h1000] = 8'h11; init_mem[16'h1001] = 8'h22;
    init_mem[16'h1002] = 8'h33; init_mem[16'h1003] = 8'h44;
    init_mem[16'h0020] = 8'h80;
    init_mem[16'h2000] = 8'hA1; init_mem[16'h2001] = 8'hB2;
    init_mem[16'h2002] = 8'hC3; init_mem[16'h2003] = 8'hD4;
    init_mem[16'h3000] = 8'h5A; init_mem[16'h3001] = 8'h6B;
    init_mem[16'hFFFE] = 8'h01; init_mem[16'hFFFF] = 8'h02;
    init_mem[16'h0000] = 8'h03; init_mem[16'h0001] = 8'h04;
    init_mem[16'h0052] = 8'h77;

    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_arbitration();
    test_abort();
    test_wrap();
    test_reset_mid_store();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
